// File: rtl/uart_tx_frame.sv
// UART transmit framer: start bit, DATA_WIDTH data bits LSB first, optional parity, stop bit; one bit per CLK.
// Latency: the start bit is driven from the accepting edge; Busy covers exactly one frame.
// Backpressure: Busy high means Data_Valid is ignored; requests are never queued.
module uart_tx_frame #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  Data_Valid,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic                  TX_OUT,
    output logic                  Busy
);

    localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t                  state;
    logic [DATA_WIDTH-1:0]   data_q;
    logic                    par_en_q;
    logic                    par_bit_q;
    logic [CNT_W-1:0]        bit_cnt;
    logic [CNT_W-1:0]        cnt_nxt;

    assign cnt_nxt = bit_cnt + CNT_W'(1);

    // TX_OUT is registered, so each transition drives the bit belonging to the state being entered.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= IDLE;
            data_q    <= '0;
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
            bit_cnt   <= '0;
            TX_OUT    <= 1'b1;
            Busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    TX_OUT <= 1'b1;
                    Busy   <= 1'b0;
                    if (Data_Valid) begin
                        data_q    <= P_DATA;
                        par_en_q  <= PAR_EN;
                        // Parity resolved at capture so later PAR_TYP changes cannot leak in.
                        par_bit_q <= (^P_DATA) ^ PAR_TYP;
                        state     <= START;
                        TX_OUT    <= 1'b0;
                        Busy      <= 1'b1;
                    end
                end
                START: begin
                    state   <= DATA;
                    bit_cnt <= '0;
                    TX_OUT  <= data_q[0];
                end
                DATA: begin
                    if (bit_cnt == LAST_BIT) begin
                        if (par_en_q) begin
                            state  <= PARITY;
                            TX_OUT <= par_bit_q;
                        end else begin
                            state  <= STOP;
                            TX_OUT <= 1'b1;
                        end
                    end else begin
                        bit_cnt <= cnt_nxt;
                        TX_OUT  <= data_q[cnt_nxt];
                    end
                end
                PARITY: begin
                    state  <= STOP;
                    TX_OUT <= 1'b1;
                end
                STOP: begin
                    state  <= IDLE;
                    TX_OUT <= 1'b1;
                    Busy   <= 1'b0;
                end
                default: begin
                    state  <= IDLE;
                    TX_OUT <= 1'b1;
                    Busy   <= 1'b0;
                end
            endcase
        end
    end

endmodule
